// File: rtl/pipe_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_pkg : shared ALU op encoding for the pipe_alu4 pipeline
// Rev 1.0
// ------------------------------------------------------------------
package pipe_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    F_ADD  = 3'd0,
    F_SUB  = 3'd1,
    F_MUL  = 3'd2,
    F_AND  = 3'd3,
    F_OR   = 3'd4,
    F_XOR  = 3'd5,
    F_SHL  = 3'd6,
    F_PASS = 3'd7
  } func_e;

endpackage
`default_nettype wire

// File: rtl/pipe_alu.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_alu : combinational 8-op ALU, results truncated to DATA_W
// Rev 1.0
// ------------------------------------------------------------------
module pipe_alu
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  func_e             func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    y = '0;
    case (func)
      F_ADD:  y = a + b;
      F_SUB:  y = a - b;
      F_MUL:  y = a * b;
      F_AND:  y = a & b;
      F_OR:   y = a | b;
      F_XOR:  y = a ^ b;
      F_SHL:  y = a << b[SH_W-1:0];
      F_PASS: y = a;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_alu4.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_alu4 : 4-stage regbank/ALU/writeback/store pipeline, full forwarding
// Rev 1.0
// ------------------------------------------------------------------
module pipe_alu4
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 16,
  parameter int ADDR_W  = 8,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [$clog2(NREG)-1:0]   rs1,
  input  logic [$clog2(NREG)-1:0]   rs2,
  input  logic [$clog2(NREG)-1:0]   rd,
  input  logic [FUNC_W-1:0]         func,
  input  logic [ADDR_W-1:0]         addr,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         z,
  input  logic [$clog2(NREG)-1:0]   dbg_raddr,
  output logic [DATA_W-1:0]         dbg_rdata,
  input  logic [ADDR_W-1:0]         mem_raddr,
  output logic [DATA_W-1:0]         mem_rdata
);

  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic              valid;
    logic [RW-1:0]     rd;
    logic [ADDR_W-1:0] addr;
    func_e             func;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic [RW-1:0]     rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] result;
  } s2_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] result;
  } s3_t;

  s1_t s1;
  s2_t s2;
  s3_t s3;

  logic [DATA_W-1:0] regbank [NREG];
  logic [DATA_W-1:0] mem     [2**ADDR_W];

  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  // One ALU serves both the S2 result and the distance-1 forward path.
  pipe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .func (s1.func),
    .a    (s1.a),
    .b    (s1.b),
    .y    (alu_y)
  );

  // Youngest producer wins: S1 (live ALU) beats S2, which beats the bank.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [RW-1:0]     src,
    input logic              s1_valid,
    input logic [RW-1:0]     s1_rd,
    input logic              s2_valid,
    input logic [RW-1:0]     s2_rd,
    input logic [DATA_W-1:0] s2_result,
    input logic [DATA_W-1:0] live,
    input logic [DATA_W-1:0] bank
  );
    if (R0_ZERO && src == '0)
      return '0;
    if (s1_valid && s1_rd == src)
      return live;
    if (s2_valid && s2_rd == src)
      return s2_result;
    return bank;
  endfunction

  assign opnd_a = select_operand(rs1, s1.valid, s1.rd, s2.valid, s2.rd,
                                 s2.result, alu_y, regbank[rs1]);
  assign opnd_b = select_operand(rs2, s1.valid, s1.rd, s2.valid, s2.rd,
                                 s2.result, alu_y, regbank[rs2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      out_valid <= 1'b0;
      z         <= '0;
    end else begin
      s1.valid  <= in_valid;
      s1.rd     <= rd;
      s1.addr   <= addr;
      s1.func   <= func_e'(func);
      s1.a      <= opnd_a;
      s1.b      <= opnd_b;

      s2.valid  <= s1.valid;
      s2.rd     <= s1.rd;
      s2.addr   <= s1.addr;
      s2.result <= alu_y;

      s3.valid  <= s2.valid;
      s3.addr   <= s2.addr;
      s3.result <= s2.result;

      out_valid <= s3.valid;
      if (s3.valid)
        z <= s3.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        regbank[k] <= DATA_W'(k);
    end else if (s2.valid && !(R0_ZERO && s2.rd == '0)) begin
      regbank[s2.rd] <= s2.result;
    end
  end

  // Memory keeps its contents across reset; only the in-flight store is dropped.
  always_ff @(posedge clk) begin
    if (!rst && s3.valid)
      mem[s3.addr] <= s3.result;
  end

  assign dbg_rdata = regbank[dbg_raddr];
  assign mem_rdata = mem[mem_raddr];

endmodule
`default_nettype wire

// File: tb/tb_pipe_alu4.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipe_alu4 : directed vector table plus random stream vs sequential model
// Rev 1.0
// ------------------------------------------------------------------
module tb_pipe_alu4;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] rs1 = '0, rs2 = '0, rd = '0, dbg_raddr = '0;
  logic [2:0] func = '0;
  logic [7:0] addr = '0, mem_raddr = '0;

  logic        ov_a, ov_z;
  logic [15:0] z_a, z_z, dbg_a, dbg_z, memr_a, memr_z;

  // Select which DUT (R0_ZERO=0 or 1) the checks observe.
  logic        use_z = 1'b0;
  logic        ov;
  logic [15:0] zo, dbgo, memo;
  assign ov   = use_z ? ov_z   : ov_a;
  assign zo   = use_z ? z_z    : z_a;
  assign dbgo = use_z ? dbg_z  : dbg_a;
  assign memo = use_z ? memr_z : memr_a;

  pipe_alu4 #(.DATA_W(16), .NREG(16), .ADDR_W(8), .R0_ZERO(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .out_valid(ov_a), .z(z_a),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_a),
    .mem_raddr(mem_raddr), .mem_rdata(memr_a)
  );

  pipe_alu4 #(.DATA_W(16), .NREG(16), .ADDR_W(8), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .out_valid(ov_z), .z(z_z),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_z),
    .mem_raddr(mem_raddr), .mem_rdata(memr_z)
  );

  typedef struct { logic [15:0] z; logic [7:0] addr; int due; } ret_t;
  typedef struct { logic [15:0] val; logic [3:0] rd; int vis; } wr_t;
  typedef struct {
    bit grp_rst; bit r0z;
    logic [3:0] s1; logic [3:0] s2; logic [3:0] d;
    logic [2:0] f; logic [7:0] ad; logic [15:0] exp;
  } vec_t;

  ret_t        rq[$];
  wr_t         wq[$];
  logic [15:0] mregs [16];
  logic [15:0] arch  [16];
  logic [15:0] mm    [256];
  bit          known [256];
  logic [15:0] last_z = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl [20];

  function automatic logic [15:0] ref_alu(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ua, ub, full;
    ua = {16'h0, a};
    ub = {16'h0, b};
    case (f)
      3'd0:    full = ua + ub;
      3'd1:    full = ua - ub;
      3'd2:    full = ua * ub;
      3'd3:    full = ua & ub;
      3'd4:    full = ua | ub;
      3'd5:    full = ua ^ ub;
      3'd6:    full = ua * (32'd1 << (ub % 32'd16));
      default: full = ua;
    endcase
    return full[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic monitor(input bit was_rst);
    logic [3:0] ra;
    while (wq.size() > 0 && wq[0].vis <= cyc) begin
      arch[wq[0].rd] = wq[0].val;
      wq.delete(0);
    end
    mem_raddr = 8'($urandom_range(0, 255));
    if (was_rst) begin
      chk("rst_out_valid", {31'h0, ov}, 32'h0);
      chk("rst_z", {16'h0, zo}, 32'h0);
    end else if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("out_valid", {31'h0, ov}, 32'h1);
      chk("z", {16'h0, zo}, {16'h0, rq[0].z});
      mm[rq[0].addr]    = rq[0].z;
      known[rq[0].addr] = 1'b1;
      last_z            = rq[0].z;
      mem_raddr         = rq[0].addr;
      rq.delete(0);
    end else begin
      chk("out_valid_idle", {31'h0, ov}, 32'h0);
      chk("z_hold", {16'h0, zo}, {16'h0, last_z});
    end
    ra = 4'($urandom_range(0, 15));
    dbg_raddr = ra;
    #1;
    chk("dbg_rdata", {16'h0, dbgo}, {16'h0, arch[ra]});
    if (known[mem_raddr])
      chk("mem_rdata", {16'h0, memo}, {16'h0, mm[mem_raddr]});
  endtask

  task automatic tick();
    bit r;
    r = rst;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor(r);
  endtask

  task automatic drive(input bit v, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] d,
                       input logic [2:0] f, input logic [7:0] ad, input bit has_exp, input logic [15:0] e);
    logic [15:0] opa, opb, res;
    in_valid = v; rs1 = a1; rs2 = a2; rd = d; func = f; addr = ad;
    if (v && !rst) begin
      opa = (use_z && a1 == 4'd0) ? 16'h0 : mregs[a1];
      opb = (use_z && a2 == 4'd0) ? 16'h0 : mregs[a2];
      res = ref_alu(f, opa, opb);
      if (!(use_z && d == 4'd0)) begin
        mregs[d] = res;
        wq.push_back('{res, d, cyc + 3});
      end
      rq.push_back('{(has_exp ? e : res), ad, cyc + 4});
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 4'd0, 4'd0, 3'd0, 8'd0, 1'b0, 16'h0);
  endtask

  // keep=1 leaves the caller's instruction on the inputs during the reset edge.
  task automatic do_reset(input bit zsel, input bit keep);
    if (zsel != use_z)
      foreach (known[i]) known[i] = 1'b0;
    use_z = zsel;
    rst = 1'b1;
    if (!keep) in_valid = 1'b0;
    rq.delete();
    wq.delete();
    last_z = '0;
    for (int k = 0; k < 16; k++) begin
      mregs[k] = 16'(k);
      arch[k]  = 16'(k);
    end
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // chain, width and op coverage (back to back, no bubbles)
    tbl[0]  = '{1, 0, 4'd8,  4'd4,  4'd8,  F_SHL,  8'd20,  16'h0080};
    tbl[1]  = '{0, 0, 4'd5,  4'd3,  4'd1,  F_ADD,  8'd125, 16'h0008};
    tbl[2]  = '{0, 0, 4'd1,  4'd1,  4'd2,  F_ADD,  8'd21,  16'h0010};
    tbl[3]  = '{0, 0, 4'd2,  4'd1,  4'd3,  F_SUB,  8'd22,  16'h0008};
    tbl[4]  = '{0, 0, 4'd2,  4'd2,  4'd4,  F_MUL,  8'd23,  16'h0100};
    tbl[5]  = '{0, 0, 4'd11, 4'd10, 4'd1,  F_SUB,  8'd24,  16'h0001};
    tbl[6]  = '{0, 0, 4'd0,  4'd1,  4'd6,  F_SUB,  8'd25,  16'hFFFF};
    tbl[7]  = '{0, 0, 4'd6,  4'd1,  4'd7,  F_ADD,  8'd26,  16'h0000};
    tbl[8]  = '{0, 0, 4'd6,  4'd8,  4'd9,  F_XOR,  8'd27,  16'hFF7F};
    tbl[9]  = '{0, 0, 4'd9,  4'd4,  4'd10, F_AND,  8'd28,  16'h0100};
    tbl[10] = '{0, 0, 4'd10, 4'd7,  4'd11, F_OR,   8'd29,  16'h0100};
    tbl[11] = '{0, 0, 4'd11, 4'd0,  4'd12, F_PASS, 8'd30,  16'h0100};
    tbl[12] = '{0, 0, 4'd9,  4'd9,  4'd13, F_MUL,  8'd31,  16'h4101};
    tbl[13] = '{0, 0, 4'd12, 4'd6,  4'd14, F_ADD,  8'd32,  16'h00FF};
    // same rd in flight twice, same addr stored repeatedly
    tbl[14] = '{1, 0, 4'd9,  4'd0,  4'd5,  F_PASS, 8'd50,  16'h0009};
    tbl[15] = '{0, 0, 4'd10, 4'd0,  4'd5,  F_PASS, 8'd50,  16'h000A};
    tbl[16] = '{0, 0, 4'd5,  4'd0,  4'd6,  F_ADD,  8'd50,  16'h000A};
    tbl[17] = '{0, 0, 4'd5,  4'd5,  4'd7,  F_ADD,  8'd50,  16'h0014};
    // register 0 hard-wired to zero
    tbl[18] = '{1, 1, 4'd5,  4'd3,  4'd0,  F_ADD,  8'd60,  16'h0008};
    tbl[19] = '{0, 1, 4'd0,  4'd4,  4'd1,  F_ADD,  8'd61,  16'h0004};

    // single op after reset
    do_reset(1'b0, 1'b0);
    drive(1'b1, 4'd5, 4'd3, 4'd1, F_ADD, 8'd125, 1'b1, 16'h0008);
    idle(5);
    dbg_raddr = 4'd1;
    mem_raddr = 8'd125;
    #1;
    chk("single_dbg_r1", {16'h0, dbgo}, 32'h8);
    chk("single_mem125", {16'h0, memo}, 32'h8);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].grp_rst) begin
        idle(5);
        do_reset(tbl[i].r0z, 1'b0);
      end
      drive(1'b1, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].f, tbl[i].ad, 1'b1, tbl[i].exp);
    end
    idle(5);

    // reset mid-stream: the edge after the 2nd instruction carries the 3rd
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 4'd9, 4'd0, 4'd15, F_PASS, 8'(70 + i), 1'b1, 16'h0009);
    idle(5);
    drive(1'b1, 4'd2, 4'd3, 4'd1, F_ADD, 8'd70, 1'b0, 16'h0);
    drive(1'b1, 4'd3, 4'd4, 4'd2, F_ADD, 8'd71, 1'b0, 16'h0);
    rs1 = 4'd4; rs2 = 4'd5; rd = 4'd3; func = F_ADD; addr = 8'd72; in_valid = 1'b1;
    do_reset(1'b0, 1'b1);
    idle(6);
    for (int i = 0; i < 3; i++) begin
      mem_raddr = 8'(70 + i);
      dbg_raddr = 4'(1 + i);
      #1;
      chk("midrst_mem", {16'h0, memo}, 32'h9);
      chk("midrst_reg", {16'h0, dbgo}, 32'(1 + i));
    end

    // random streams with gaps, both register-0 flavours
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(pass == 1, 1'b0);
      for (int n = 0; n < (pass == 0 ? 1000 : 300); n++) begin
        if ($urandom_range(0, 3) == 0)
          idle(1 + int'($urandom_range(0, 2)));
        drive(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
              8'($urandom_range(0, 31)), 1'b0, 16'h0);
      end
      idle(6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
